// File: rtl/permuter_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : permuter_arb_ctrl
//  Description : Arbitration/steering control for one 2x2 permuter stage of a
//                deflection-routed network. Inputs are ranked by golden
//                packet id, then age, then a round-robin pointer. The control
//                produces a registered swap select, the winning input index
//                and per-input deflection flags. A free-running epoch counter
//                advances the golden packet id.
//                Optional macro PERM_ARB_STATS_EN adds a saturating
//                deflection-cycle counter with a synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module permuter_arb_ctrl #(
    parameter int AGE_W     = 4,
    parameter int ID_W      = 3,
    parameter int EPOCH_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid0,
    input  logic             in_valid1,
    input  logic             in_pref0,
    input  logic             in_pref1,
    input  logic [AGE_W-1:0] in_age0,
    input  logic [AGE_W-1:0] in_age1,
    input  logic [ID_W-1:0]  in_id0,
    input  logic [ID_W-1:0]  in_id1,
    input  logic             stall,
`ifdef PERM_ARB_STATS_EN
    input  logic             stat_clr,
    output logic [15:0]      defl_count,
`endif
    output logic             swap,
    output logic             winner,
    output logic             deflect0,
    output logic             deflect1,
    output logic [ID_W-1:0]  golden_id
);

    // Epoch counter is sized for the largest legal epoch length (65535).
    localparam logic [15:0] c_EPOCH_LAST = 16'(EPOCH_LEN - 1);

    logic [15:0]     epoch_q;
    logic [ID_W-1:0] golden_q;
    logic            swap_q,   swap_d;
    logic            winner_q, winner_d;
    logic            defl0_q,  defl0_d;
    logic            defl1_q,  defl1_d;
    logic            rr_q,     rr_d;

    logic            w_gold0;
    logic            w_gold1;
    logic            w_rank;
    logic            w_tie;

    // Rank the two inputs: golden first, then older age, then round-robin.
    always_comb begin
        w_gold0 = (in_id0 == golden_q);
        w_gold1 = (in_id1 == golden_q);
        w_tie   = 1'b0;
        if (w_gold0 != w_gold1) begin
            w_rank = w_gold1;
        end else if (in_age0 != in_age1) begin
            w_rank = (in_age1 > in_age0);
        end else begin
            w_rank = rr_q;
            w_tie  = 1'b1;
        end
    end

    // Next-state decision; stall freezes everything, idle clears deflections.
    always_comb begin
        swap_d   = swap_q;
        winner_d = winner_q;
        defl0_d  = defl0_q;
        defl1_d  = defl1_q;
        rr_d     = rr_q;
        if (!stall) begin
            defl0_d = 1'b0;
            defl1_d = 1'b0;
            case ({in_valid1, in_valid0})
                2'b11: begin
                    winner_d = w_rank;
                    swap_d   = w_rank ? ~in_pref1 : in_pref0;
                    // Same productive port wanted: the loser is deflected.
                    if (in_pref0 == in_pref1) begin
                        defl0_d = w_rank;
                        defl1_d = ~w_rank;
                    end
                    if (w_tie) begin
                        rr_d = ~rr_q;
                    end
                end
                2'b01: begin
                    winner_d = 1'b0;
                    swap_d   = in_pref0;
                end
                2'b10: begin
                    winner_d = 1'b1;
                    swap_d   = ~in_pref1;
                end
                default: begin
                    // Nothing present: keep the last steering setting.
                end
            endcase
        end
    end

    // Decision registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_q   <= 1'b0;
            winner_q <= 1'b0;
            defl0_q  <= 1'b0;
            defl1_q  <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            swap_q   <= swap_d;
            winner_q <= winner_d;
            defl0_q  <= defl0_d;
            defl1_q  <= defl1_d;
            rr_q     <= rr_d;
        end
    end

    // Epoch counter runs every cycle (stall does not stop it) and advances
    // the golden packet id on each wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epoch_q  <= '0;
            golden_q <= '0;
        end else if (epoch_q == c_EPOCH_LAST) begin
            epoch_q  <= '0;
            golden_q <= golden_q + 1'b1;
        end else begin
            epoch_q  <= epoch_q + 16'd1;
        end
    end

`ifdef PERM_ARB_STATS_EN
    logic [15:0] defl_cnt_q;

    // Saturating count of cycles with any deflection shown; clear dominates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            defl_cnt_q <= '0;
        end else if (stat_clr) begin
            defl_cnt_q <= '0;
        end else if ((defl0_q | defl1_q) && (defl_cnt_q != 16'hFFFF)) begin
            defl_cnt_q <= defl_cnt_q + 16'd1;
        end
    end

    assign defl_count = defl_cnt_q;
`endif

    assign swap      = swap_q;
    assign winner    = winner_q;
    assign deflect0  = defl0_q;
    assign deflect1  = defl1_q;
    assign golden_id = golden_q;

endmodule
`default_nettype wire

// File: tb/tb_permuter_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_permuter_arb_ctrl
//  Description : Directed, table-driven bench for permuter_arb_ctrl with
//                hand-written sequences for epoch/golden and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_permuter_arb_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid0, in_valid1, in_pref0, in_pref1, stall;
    logic [3:0] in_age0, in_age1;
    logic [2:0] in_id0, in_id1;
    logic       swap, winner, deflect0, deflect1;
    logic [2:0] golden_id;
`ifdef PERM_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] defl_count;
`endif

    permuter_arb_ctrl #(.AGE_W(4), .ID_W(3), .EPOCH_LEN(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid0 (in_valid0),
        .in_valid1 (in_valid1),
        .in_pref0  (in_pref0),
        .in_pref1  (in_pref1),
        .in_age0   (in_age0),
        .in_age1   (in_age1),
        .in_id0    (in_id0),
        .in_id1    (in_id1),
        .stall     (stall),
`ifdef PERM_ARB_STATS_EN
        .stat_clr  (stat_clr),
        .defl_count(defl_count),
`endif
        .swap      (swap),
        .winner    (winner),
        .deflect0  (deflect0),
        .deflect1  (deflect1),
        .golden_id (golden_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v0, v1, p0, p1, g0, g1, st;
        logic [3:0] a0, a1;
        logic       sw, win, d0, d1;
    } vec_t;

    vec_t vecs[15];
    int   tests = 0;
    int   fails = 0;
    int   edges = 0;

    function automatic logic [2:0] gold_model();
        return 3'((edges / 16) % 8);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic drive(input logic v0, v1, p0, p1, g0, g1, st,
                         input logic [3:0] a0, a1);
        in_valid0 = v0; in_valid1 = v1;
        in_pref0  = p0; in_pref1  = p1;
        in_age0   = a0; in_age1   = a1;
        in_id0    = g0 ? gold_model() : gold_model() + 3'd1;
        in_id1    = g1 ? gold_model() : gold_model() + 3'd1;
        stall     = st;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
        tick();
    endtask

    task automatic chk_outs(input string nm, input logic sw, win, d0, d1);
        chk({nm, ".swap"},   int'(swap),     int'(sw));
        chk({nm, ".winner"}, int'(winner),   int'(win));
        chk({nm, ".defl0"},  int'(deflect0), int'(d0));
        chk({nm, ".defl1"},  int'(deflect1), int'(d1));
    endtask

    initial begin
        //          v0 v1 p0 p1 g0 g1 st  a0     a1      sw win d0 d1
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 4'd5, 4'd9,  1, 1, 1, 0}; // older in1
        vecs[1]  = '{1, 1, 1, 1, 0, 0, 0, 4'd3, 4'd3,  1, 0, 0, 1}; // tie rr=0
        vecs[2]  = '{1, 1, 1, 1, 0, 0, 0, 4'd3, 4'd3,  0, 1, 1, 0}; // tie rr=1
        vecs[3]  = '{1, 0, 1, 0, 0, 0, 0, 4'd0, 4'd9,  1, 0, 0, 0}; // only in0
        vecs[4]  = '{0, 1, 0, 1, 0, 0, 0, 4'd9, 4'd0,  0, 1, 0, 0}; // only in1
        vecs[5]  = '{0, 0, 1, 1, 0, 0, 0, 4'd1, 4'd1,  0, 1, 0, 0}; // idle holds
        vecs[6]  = '{1, 1, 0, 1, 0, 0, 0, 4'd7, 4'd2,  0, 0, 0, 0}; // no conflict
        vecs[7]  = '{1, 1, 0, 0, 1, 0, 0, 4'd0, 4'd15, 0, 0, 0, 1}; // golden in0
        vecs[8]  = '{1, 1, 1, 0, 1, 1, 0, 4'd4, 4'd4,  1, 0, 0, 0}; // both gold rr=0
        vecs[9]  = '{1, 1, 0, 0, 0, 0, 0, 4'd2, 4'd2,  1, 1, 1, 0}; // tie rr=1
        vecs[10] = '{1, 1, 0, 0, 0, 0, 1, 4'd1, 4'd9,  1, 1, 1, 0}; // stall
        vecs[11] = '{0, 1, 1, 1, 0, 0, 1, 4'd6, 4'd6,  1, 1, 1, 0}; // stall
        vecs[12] = '{1, 1, 1, 1, 0, 0, 1, 4'd6, 4'd6,  1, 1, 1, 0}; // stall, tie
        vecs[13] = '{1, 1, 0, 1, 0, 0, 0, 4'd6, 4'd6,  0, 0, 0, 0}; // rr still 0
        vecs[14] = '{1, 1, 0, 1, 0, 0, 0, 4'd6, 4'd6,  0, 1, 0, 0}; // rr=1

        // Power-on reset
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
        #12;
        chk_outs("reset", 0, 0, 0, 0);
        chk("reset.golden", int'(golden_id), 0);
        reset = 1'b0;
        edges = 0;

        // Table-driven decisions (edges 1..15, golden stays 0)
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v0, vecs[i].v1, vecs[i].p0, vecs[i].p1,
                  vecs[i].g0, vecs[i].g1, vecs[i].st, vecs[i].a0, vecs[i].a1);
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].sw, vecs[i].win,
                     vecs[i].d0, vecs[i].d1);
            chk($sformatf("vec%0d.golden", i), int'(golden_id), int'(gold_model()));
        end

        // Epoch wrap after 16 edges from reset (stall cycles included)
        idle();
        chk("epoch16.golden", int'(golden_id), 1);
        chk_outs("idle_after", 0, 1, 0, 0);

        // Golden input beats much older non-golden input
        while (edges < 32) idle();
        chk("epoch32.golden", int'(golden_id), 2);
        drive(1, 1, 0, 0, 0, 1, 0, 4'd15, 4'd0);
        chk("gold_seq.id1", int'(in_id1), 2);
        tick();
        chk_outs("gold_seq", 1, 1, 1, 0);

        // Asynchronous reset mid-epoch: counter 7, golden 3, swap 1
        while (edges < 54) idle();
        drive(1, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
        tick();
        chk("pre_rst.swap", int'(swap), 1);
        chk("pre_rst.golden", int'(golden_id), 3);
        #2 reset = 1'b1;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0);
        chk("async_rst.golden", int'(golden_id), 0);
        reset = 1'b0;
        edges = 0;
        // Epoch restarts at 0: golden must stay 0 until 16 edges elapse
        for (int i = 0; i < 15; i++) idle();
        chk("post_rst15.golden", int'(golden_id), 0);
        idle();
        chk("post_rst16.golden", int'(golden_id), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/permuter_arb_ctrl.md
PERMUTER_ARB_CTRL -- requirements
Module: permuter_arb_ctrl

Interface
REQ-001 SHALL have parameter AGE_W, default 4, width of flit age field; larger value is older.
REQ-002 SHALL have parameter ID_W, default 3, width of packet-id field used for golden matching.
REQ-003 SHALL have parameter EPOCH_LEN, default 16, cycles per golden epoch, legal range 2..65535.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid0, in_valid1  in  1  flit present on permuter input 0 / 1.
REQ-007 SHALL have ports in_pref0, in_pref1  in  1  productive output port requested by input 0 / 1 (0 = out0, 1 = out1).
REQ-008 SHALL have ports in_age0, in_age1  in  AGE_W  flit age.
REQ-009 SHALL have ports in_id0, in_id1  in  ID_W  flit packet id.
REQ-010 SHALL have port stall  in  1  freeze decision registers.
REQ-011 SHALL have port swap  out  1  registered swap control for the 2x2 permuter stage.
REQ-012 SHALL have port winner  out  1  registered index of prioritised input.
REQ-013 SHALL have ports deflect0, deflect1  out  1  registered: input 0 / 1 flit routed to non-preferred port.
REQ-014 SHALL have port golden_id  out  ID_W  current golden packet id.

Function
REQ-015 SHALL sample inputs at rising edge N when stall=0 and present swap/winner/deflect0/deflect1 from edge N; latency exactly 1 cycle.
REQ-016 SHALL rank inputs: golden (in_id == golden_id) beats non-golden; then larger age wins; then round-robin pointer rr decides (rr=0 favours input 0).
REQ-017 SHALL, when exactly one input valid, make it winner with no deflection; rr unchanged.
REQ-018 SHALL, when both invalid, hold swap, winner, rr; clear deflect0/deflect1.
REQ-019 SHALL set swap = in_pref0 when winner=0, swap = ~in_pref1 when winner=1.
REQ-020 SHALL, when both valid and in_pref0 == in_pref1, assert deflect of the loser only; otherwise both deflect flags 0.
REQ-021 SHALL toggle rr only in cycles where both valid, both golden-equal, ages equal, stall=0.
REQ-022 SHALL, while stall=1, hold swap, winner, deflect0, deflect1, rr unchanged and ignore inputs.
REQ-023 SHALL run an epoch counter 0..EPOCH_LEN-1 every cycle regardless of stall; on wrap to 0, golden_id increments modulo 2^ID_W.
REQ-024 SHALL treat both inputs golden as a golden tie resolved by age then rr.

Reset
REQ-025 SHALL on reset=1 immediately clear swap, winner, deflect0, deflect1, rr, epoch counter, golden_id to 0, including mid-epoch and during stall.
REQ-026 SHALL make first decision at first rising edge with reset=0, epoch counter starting at 0.

Configuration
REQ-027 SHALL, with macro PERM_ARB_STATS_EN defined, add ports stat_clr in 1 and defl_count out 16: counter increments by 1 per cycle with deflect0|deflect1 asserted, saturates at 65535, synchronous clear by stat_clr (clear wins over increment), reset to 0.
REQ-028 SHALL, without PERM_ARB_STATS_EN, omit stat_clr, defl_count and the counter logic; all other behaviour identical.

Verification
REQ-029 SHALL cover: both valid, ids non-golden, age0=5, age1=9, pref0=pref1=0 -> next cycle winner=1, swap=1, deflect0=1, deflect1=0.
REQ-030 SHALL cover: both valid, ages equal 3, pref0=pref1=1, rr=0, two consecutive cycles -> winner 0 then 1, swap 1 then 0, rr toggles each cycle.
REQ-031 SHALL cover: golden_id=2, in_id1=2, age1=0, age0=15, conflicting prefs -> winner=1, deflect0=1.
REQ-032 SHALL cover: stall=1 for 3 cycles with changing inputs -> swap/winner/deflect held; epoch still advances; after EPOCH_LEN=16 cycles from reset golden_id=1.
REQ-033 SHALL cover: reset asserted mid-epoch (counter 7, golden_id 3, swap 1) -> all outputs 0 asynchronously before next edge.
REQ-034 SHALL cover with PERM_ARB_STATS_EN: 65537 conflicting cycles -> defl_count=65535; stat_clr=1 same cycle as deflection -> 0.
